cop_mem_responder: RTL and testbench

//  Responder (memory-side) end of the COP memory interface: a word-addressed SRAM

---
 rtl/cop_mem_responder.sv | 158 +++++++++++++++
 tb/tb_cop_mem_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cop_mem_responder.sv
// ============================================================================
// Module   : cop_mem_responder
// Purpose  : Memory-side responder for the COP memory interface (SRAM model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module cop_mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic [3:0]  cfg_wait,
  input  logic        cop_mem_cen,
  input  logic        cop_mem_wen,
  input  logic [31:0] cop_mem_addr,
  input  logic [31:0] cop_mem_wdata,
  input  logic [3:0]  cop_mem_ben,
  output logic [31:0] cop_mem_rdata,
  output logic        cop_mem_stall,
  output logic        cop_mem_error,
  output logic [15:0] txn_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_ben;
  logic [31:0] r_rdata;
  logic        r_stall;
  logic        r_error;
  logic [15:0] r_txn;
  logic [31:0] w_rdata_nxt;
  logic        w_error_nxt;
  logic        w_stall_nxt;
  logic [15:0] w_txn_nxt;

  logic [31:0] r_mem [DEPTH];

  logic          w_accept;
  logic          w_t_wen;
  logic [31:0]   w_t_addr;
  logic [31:0]   w_t_off;
  logic          w_t_bad;
  logic [AW-1:0] w_t_idx;
  logic [31:0]   w_c_off;
  logic          w_c_bad;
  logic [AW-1:0] w_c_idx;
  logic          w_commit;
  logic [31:0]   w_rd_word;

  assign w_accept = cop_mem_cen && (r_state == ST_IDLE || r_state == ST_RESP);

  // Transaction heading for RESP at the next edge: new request or held one.
  assign w_t_wen  = w_accept ? cop_mem_wen  : r_wen;
  assign w_t_addr = w_accept ? cop_mem_addr : r_addr;
  assign w_t_off  = w_t_addr - BASE_ADDR;
  assign w_t_bad  = (w_t_off[1:0] != 2'b00) || (w_t_off[31:AW+2] != '0);
  assign w_t_idx  = w_t_off[AW+1:2];

  // Transaction currently in RESP, whose write commits at this edge.
  assign w_c_off  = r_addr - BASE_ADDR;
  assign w_c_bad  = (w_c_off[1:0] != 2'b00) || (w_c_off[31:AW+2] != '0);
  assign w_c_idx  = w_c_off[AW+1:2];
  assign w_commit = (r_state == ST_RESP) && r_wen && !w_c_bad;

  // A read following a write to the same word sees the bytes committing now.
  always_comb begin
    w_rd_word = r_mem[w_t_idx];
    if (w_commit && (w_c_idx == w_t_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (r_ben[b]) w_rd_word[8*b +: 8] = r_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_accept) begin
          w_cnt_nxt   = cfg_wait;
          w_state_nxt = (cfg_wait != 4'd0) ? ST_WAIT : ST_RESP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = ST_RESP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_stall_nxt = (w_state_nxt == ST_WAIT);
    w_error_nxt = (w_state_nxt == ST_RESP) && w_t_bad;
    w_rdata_nxt = ((w_state_nxt == ST_RESP) && !w_t_wen && !w_t_bad) ? w_rd_word : 32'h0;
    w_txn_nxt   = (w_state_nxt == ST_RESP) ? r_txn + 16'd1 : r_txn;
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_wen   <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_ben   <= 4'h0;
      r_rdata <= 32'h0;
      r_stall <= 1'b0;
      r_error <= 1'b0;
      r_txn   <= 16'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rdata <= w_rdata_nxt;
      r_stall <= w_stall_nxt;
      r_error <= w_error_nxt;
      r_txn   <= w_txn_nxt;
      if (w_accept) begin
        r_wen   <= cop_mem_wen;
        r_addr  <= cop_mem_addr;
        r_wdata <= cop_mem_wdata;
        r_ben   <= cop_mem_ben;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_reset && w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_ben[b]) r_mem[w_c_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  assign cop_mem_rdata = r_rdata;
  assign cop_mem_stall = r_stall;
  assign cop_mem_error = r_error;
  assign txn_count     = r_txn;

endmodule

`default_nettype wire

// File: tb/tb_cop_mem_responder.sv
// ============================================================================
// Module   : tb_cop_mem_responder
// Purpose  : Directed scoreboard bench for cop_mem_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cop_mem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic [3:0]  cfg_wait;
  logic        cop_mem_cen;
  logic        cop_mem_wen;
  logic [31:0] cop_mem_addr;
  logic [31:0] cop_mem_wdata;
  logic [3:0]  cop_mem_ben;
  logic [31:0] cop_mem_rdata;
  logic        cop_mem_stall;
  logic        cop_mem_error;
  logic [15:0] txn_count;

  cop_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut (
    .g_clk         (g_clk),
    .g_reset       (g_reset),
    .cfg_wait      (cfg_wait),
    .cop_mem_cen   (cop_mem_cen),
    .cop_mem_wen   (cop_mem_wen),
    .cop_mem_addr  (cop_mem_addr),
    .cop_mem_wdata (cop_mem_wdata),
    .cop_mem_ben   (cop_mem_ben),
    .cop_mem_rdata (cop_mem_rdata),
    .cop_mem_stall (cop_mem_stall),
    .cop_mem_error (cop_mem_error),
    .txn_count     (txn_count)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_count = 16'h0;
  logic [31:0] wdat [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request, walks its wait states and checks the response cycle.
  // Returns #1 into the response cycle so the caller may chain back-to-back.
  task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] ben, input logic [3:0] wt,
                        input logic [31:0] exp_rd, input logic exp_err);
    resp_t r;
    cfg_wait      = wt;
    cop_mem_cen   = 1'b1;
    cop_mem_wen   = wen;
    cop_mem_addr  = addr;
    cop_mem_wdata = wdata;
    cop_mem_ben   = ben;
    r.rdata = exp_rd;
    r.err   = exp_err;
    sb.push_back(r);
    @(posedge g_clk); #1;
    for (int i = 0; i < int'(wt); i++) begin
      chk("wait_stall", {31'h0, cop_mem_stall}, 32'h1);
      chk("wait_error", {31'h0, cop_mem_error}, 32'h0);
      chk("wait_rdata", cop_mem_rdata, 32'h0);
      @(posedge g_clk); #1;
    end
    r = sb.pop_front();
    exp_count++;
    chk("resp_stall", {31'h0, cop_mem_stall}, 32'h0);
    chk("resp_rdata", cop_mem_rdata, r.rdata);
    chk("resp_error", {31'h0, cop_mem_error}, {31'h0, r.err});
    chk("txn_count", {16'h0, txn_count}, {16'h0, exp_count});
  endtask

  task automatic idle(input int n);
    cop_mem_cen = 1'b0;
    repeat (n) begin
      @(posedge g_clk); #1;
      chk("idle_stall", {31'h0, cop_mem_stall}, 32'h0);
      chk("idle_error", {31'h0, cop_mem_error}, 32'h0);
      chk("idle_rdata", cop_mem_rdata, 32'h0);
    end
  endtask

  initial begin
    g_reset = 1'b1; cfg_wait = 4'd0; cop_mem_cen = 1'b0; cop_mem_wen = 1'b0;
    cop_mem_addr = 32'h0; cop_mem_wdata = 32'h0; cop_mem_ben = 4'h0;
    repeat (2) @(posedge g_clk);
    #1;
    chk("rst_stall", {31'h0, cop_mem_stall}, 32'h0);
    chk("rst_error", {31'h0, cop_mem_error}, 32'h0);
    chk("rst_rdata", cop_mem_rdata, 32'h0);
    chk("rst_txn", {16'h0, txn_count}, 32'h0);
    g_reset = 1'b0;
    idle(1);

    // Full write then back-to-back read of the same word
    do_txn(1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 4'b1111, 4'd0, 32'h0, 1'b0);
    do_txn(1'b0, BASE + 32'd8, 32'h0, 4'b0000, 4'd0, 32'hDEAD_BEEF, 1'b0);
    idle(1);

    // Single-byte write merges into the existing word
    do_txn(1'b1, BASE + 32'd8, 32'h0000_AB00, 4'b0010, 4'd0, 32'h0, 1'b0);
    do_txn(1'b0, BASE + 32'd8, 32'h0, 4'b1111, 4'd0, 32'hDEAD_ABEF, 1'b0);
    idle(1);

    do_txn(1'b0, BASE + 32'd8, 32'h0, 4'b0000, 4'd3, 32'hDEAD_ABEF, 1'b0);
    idle(1);

    // Out-of-window and misaligned accesses; word 0 must survive
    do_txn(1'b1, BASE, 32'h1111_1111, 4'b1111, 4'd0, 32'h0, 1'b0);
    do_txn(1'b1, BASE + 32'(4*DEPTH), 32'h1234_5678, 4'b1111, 4'd0, 32'h0, 1'b1);
    do_txn(1'b0, BASE + 32'd2, 32'h0, 4'b0000, 4'd0, 32'h0, 1'b1);
    do_txn(1'b0, BASE - 32'd4, 32'h0, 4'b0000, 4'd0, 32'h0, 1'b1);
    do_txn(1'b0, BASE, 32'h0, 4'b0000, 4'd0, 32'h1111_1111, 1'b0);
    do_txn(1'b1, BASE, 32'hFFFF_FFFF, 4'b0000, 4'd2, 32'h0, 1'b0);
    do_txn(1'b0, BASE, 32'h0, 4'b0000, 4'd0, 32'h1111_1111, 1'b0);
    idle(1);

    // Reset during a wait state abandons the write
    cfg_wait = 4'd5; cop_mem_cen = 1'b1; cop_mem_wen = 1'b1;
    cop_mem_addr = BASE + 32'd8; cop_mem_wdata = 32'hCAFE_F00D; cop_mem_ben = 4'b1111;
    @(posedge g_clk); #1;
    chk("rstw_stall1", {31'h0, cop_mem_stall}, 32'h1);
    @(posedge g_clk); #1;
    chk("rstw_stall2", {31'h0, cop_mem_stall}, 32'h1);
    g_reset = 1'b1; cop_mem_cen = 1'b0;
    @(posedge g_clk); #1;
    exp_count = 16'h0;
    chk("rstw_stall", {31'h0, cop_mem_stall}, 32'h0);
    chk("rstw_txn", {16'h0, txn_count}, 32'h0);
    chk("rstw_error", {31'h0, cop_mem_error}, 32'h0);
    g_reset = 1'b0;
    idle(2);
    do_txn(1'b0, BASE + 32'd8, 32'h0, 4'b0000, 4'd0, 32'hDEAD_ABEF, 1'b0);

    // Streaming writes and reads at one transaction per cycle
    for (int i = 0; i < 4; i++) wdat[i] = $urandom;
    for (int i = 0; i < 4; i++)
      do_txn(1'b1, BASE + 32'd16 + 32'(4*i), wdat[i], 4'b1111, 4'd0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      do_txn(1'b0, BASE + 32'd16 + 32'(4*i), 32'h0, 4'b0000, 4'd0, wdat[i], 1'b0);
    idle(2);

    // Counter wrap
    force u_dut.r_txn = 16'hFFFE;
    @(posedge g_clk); #1;
    release u_dut.r_txn;
    exp_count = 16'hFFFE;
    do_txn(1'b0, BASE + 32'd8, 32'h0, 4'b0000, 4'd0, 32'hDEAD_ABEF, 1'b0);
    do_txn(1'b0, BASE + 32'd8, 32'h0, 4'b0000, 4'd0, 32'hDEAD_ABEF, 1'b0);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
